// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory address arbiter: FSM encoding,
// arbitration policy codes and default geometry of the shared word memory.
package mem_arb_pkg;

   // Default geometry of the shared word memory.
   localparam int MEM_DEPTH      = 1024;
   localparam int ADDR_WIDTH_DEF = $clog2(MEM_DEPTH);
   localparam int WORD_WIDTH_DEF = 16;
   localparam int NUM_CH_DEF     = 8;

   // Arbitration policy selector values for RR_MODE.
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Arbiter FSM: IDLE means no address is being presented, BUSY means
   // out_valid is high and a captured address waits for out_ready.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Next channel index after idx, wrapping at n.
   function automatic int next_index(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-base priority encoder. The search starts at channel 'base' and
// wraps from N-1 back to 0; the first eligible request found wins. One
// channel can be removed from the search (mask_en/mask_idx) so that a
// channel whose transfer is completing this cycle is not picked again on
// the same edge. With base tied to 0 this is a plain fixed-priority encoder.
module rr_pick #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   input  logic          mask_en,
   input  logic [IW-1:0] mask_idx,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [N-1:0] eligible;

   // Remove the masked channel from the candidate set.
   always_comb begin
      eligible = req;
      if (mask_en) begin
         eligible[mask_idx] = 1'b0;
      end
   end

   // Walk the channels from the furthest offset down to offset 0 so that the
   // candidate closest to base is the last one written and therefore wins.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(base) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (eligible[IW'(j)]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/mem_addr_arbiter.sv
// N-channel address arbiter in front of the shared word memory. Picks one
// requesting channel (fixed priority or round-robin), registers its address
// and presents it with a valid/ready handshake; the winner receives a
// one-cycle grant in the cycle its transfer is accepted.
//
// Handshake: a transfer completes in any cycle where out_valid and out_ready
// are both high. out_addr/out_sel/out_oor are stable while out_valid is high
// and out_ready is low. gnt[out_sel] pulses in the completing cycle only,
// and on that same edge the next winner (excluding the channel just served)
// is loaded so a continuous stream needs no idle cycle between addresses.
module mem_addr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int  NUM_CH     = NUM_CH_DEF,
   parameter int  WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int  ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int  RR_MODE    = ARB_RR,
   localparam int SEL_W      = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            req,
   input  logic [NUM_CH*WORD_WIDTH-1:0] addr_in,
   output logic [NUM_CH-1:0]            gnt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_WIDTH-1:0]        out_addr,
   output logic [SEL_W-1:0]             out_sel,
   output logic                         out_oor,
   output arb_state_t                   state_dbg
);

   arb_state_t           state;
   logic [SEL_W-1:0]     rr_ptr;
   logic [SEL_W-1:0]     next_ptr;
   logic [SEL_W-1:0]     pick_base;
   logic                 pick_found;
   logic [SEL_W-1:0]     pick_idx;
   logic [WORD_WIDTH-1:0] win_word;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic                 win_oor;
   logic                 fire;

   assign state_dbg = state;

   // A transfer completes when the presented address is accepted.
   assign fire = (state == BUSY) && out_valid && out_ready;

   // Pointer value after the channel in out_sel has been served.
   always_comb begin
      next_ptr = SEL_W'(next_index(int'(out_sel), NUM_CH));
   end

   // Search base: round-robin starts just past the last served channel (using
   // the post-completion pointer on a completing edge); fixed priority
   // always starts at channel 0.
   always_comb begin
      pick_base = '0;
      if (RR_MODE == ARB_RR) begin
         pick_base = fire ? next_ptr : rr_ptr;
      end
   end

   rr_pick #(
      .N  (NUM_CH),
      .IW (SEL_W)
   ) u_pick (
      .req      (req),
      .base     (pick_base),
      .mask_en  (fire),
      .mask_idx (out_sel),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   // Select the winning channel's address word from the packed input bus.
   always_comb begin
      win_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick_idx == SEL_W'(i)) begin
            win_word = addr_in[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   // Truncate to the memory address width and flag any discarded high bits.
   always_comb begin
      win_addr = ADDR_WIDTH'(win_word);
      win_oor  = |(win_word >> ADDR_WIDTH);
   end

   // One-hot grant to the channel whose transfer completes this cycle; a
   // cycle with reset asserted never grants.
   always_comb begin
      gnt = '0;
      if (fire && !rst) begin
         gnt[out_sel] = 1'b1;
      end
   end

   // Arbiter FSM: capture a winner from IDLE, hold it while stalled, and on
   // completion either load the next winner back-to-back or return to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_sel   <= '0;
         out_oor   <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state     <= BUSY;
                  out_valid <= 1'b1;
                  out_addr  <= win_addr;
                  out_sel   <= pick_idx;
                  out_oor   <= win_oor;
               end
            end
            BUSY: begin
               if (fire) begin
                  rr_ptr <= next_ptr;
                  if (pick_found) begin
                     out_addr <= win_addr;
                     out_sel  <= pick_idx;
                     out_oor  <= win_oor;
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
